// File: rtl/ldn_cn_minsel_issue_if.sv
// ---------------------------------------------------------------------------
// ldn_cn_minsel_issue_if
//
// Bundles the three buses of the check-node min-selection issue unit:
//   message stream   : msg_valid_i / msg_ready_o / msg_data_i / msg_last_i
//   ALU issue side   : fu_data_o / fu_valid_o / alu_result_i
//   result stream    : res_valid_o / res_ready_i / res_min1_o / res_min2_o /
//                      res_count_o / res_err_o
//
// Signal suffixes are written from the issue unit's point of view.
// Modport 'slave' is taken by the issue unit, 'master' by whatever feeds
// messages, models the ALU and consumes results.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and payload
// stable until that edge; ready may be asserted independently of valid.
// ---------------------------------------------------------------------------
interface ldn_cn_minsel_issue_if #(
  parameter int Q     = 8,
  parameter int SIMD  = 4,
  parameter int XLEN  = 64,
  parameter int CNT_W = 5,
  parameter int TID_W = 3
);

  localparam int W = Q * SIMD;

  // ALU request word. Field order is fixed: the issue unit packs it as a
  // flat concatenation in exactly this order.
  typedef struct packed {
    logic [3:0]       fu;
    logic [7:0]       operation;
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
    logic [XLEN-1:0]  imm;
    logic [TID_W-1:0] trans_id;
  } fu_data_t;

  // message stream
  logic             msg_valid_i;
  logic             msg_ready_o;
  logic [W-1:0]     msg_data_i;
  logic             msg_last_i;

  // ALU issue side
  fu_data_t         fu_data_o;
  logic             fu_valid_o;
  logic [XLEN-1:0]  alu_result_i;

  // result stream
  logic             res_valid_o;
  logic             res_ready_i;
  logic [W-1:0]     res_min1_o;
  logic [W-1:0]     res_min2_o;
  logic [CNT_W-1:0] res_count_o;
  logic             res_err_o;

  modport slave (
    input  msg_valid_i, msg_data_i, msg_last_i,
    output msg_ready_o,
    output fu_data_o, fu_valid_o,
    input  alu_result_i,
    output res_valid_o, res_min1_o, res_min2_o, res_count_o, res_err_o,
    input  res_ready_i
  );

  modport master (
    output msg_valid_i, msg_data_i, msg_last_i,
    input  msg_ready_o,
    input  fu_data_o, fu_valid_o,
    output alu_result_i,
    input  res_valid_o, res_min1_o, res_min2_o, res_count_o, res_err_o,
    output res_ready_i
  );

endinterface

// File: rtl/ldn_cn_minsel_issue.sv
// ---------------------------------------------------------------------------
// ldn_cn_minsel_issue
//
// Check-node min-selection issue unit for the i8x4 non-binary LDPC path.
// Each accepted message (4 signed 8-bit lanes) is folded into per-lane
// running min1/min2 by issuing three LDN ops to the ALU and capturing the
// combinational ALU result in the same cycle:
//   OP_MAX  : t    = LDN_IDXMINUP2(min1, v)   per-lane signed max
//   OP_MIN2 : min2 = LDN_MIN(min2, t)
//   OP_MIN1 : min1 = LDN_MIN(min1, v)
// After the last message of a node (or after MAX_DEG messages) the result
// {min1, min2, count, err} is offered on the result stream.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          ldn_cn_minsel_issue_if.slave (message, ALU, result buses)
//   dbg_state_o  current FSM state encoding (IDLE=0, OP_MAX=1, OP_MIN2=2,
//                OP_MIN1=3, DONE=4)
// ---------------------------------------------------------------------------
module ldn_cn_minsel_issue #(
  parameter int Q       = 8,
  parameter int SIMD    = 4,
  parameter int MAX_DEG = 16,
  parameter int XLEN    = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  ldn_cn_minsel_issue_if.slave        bus,
  output logic [2:0]                  dbg_state_o
);

  localparam int W     = Q * SIMD;
  localparam int CNT_W = 5;
  localparam int TID_W = 3;

  // ALU decode values; these must agree with the ALU's operator encoding.
  localparam logic [3:0] FU_ALU           = 4'd3;
  localparam logic [7:0] OP_ADD           = 8'd0;
  localparam logic [7:0] OP_LDN_MIN       = 8'd114;
  localparam logic [7:0] OP_LDN_IDXMINUP2 = 8'd115;

  // +127 in every lane: the identity for a signed per-lane minimum.
  localparam logic [W-1:0] MIN_INIT = {SIMD{{1'b0, {(Q-1){1'b1}}}}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OP_MAX  = 3'd1,
    ST_OP_MIN2 = 3'd2,
    ST_OP_MIN1 = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     min1_q, min1_d;
  logic [W-1:0]     min2_q, min2_d;
  logic [W-1:0]     vreg_q, vreg_d;
  logic [W-1:0]     treg_q, treg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             msg_ready;
  logic             fu_valid;
  logic [7:0]       op_sel;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     alu_res;
  logic [CNT_W-1:0] cnt_inc;
  logic             deg_hit;
  logic             unused_alu_hi;

  assign alu_res       = bus.alu_result_i[W-1:0];
  assign unused_alu_hi = ^bus.alu_result_i[XLEN-1:W];

  // The message being accepted is the MAX_DEG-th of the node.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign deg_hit = (cnt_inc == CNT_W'(MAX_DEG));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      min1_q  <= MIN_INIT;
      min2_q  <= MIN_INIT;
      vreg_q  <= '0;
      treg_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      vreg_q  <= vreg_d;
      treg_q  <= treg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and issue logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    min1_d    = min1_q;
    min2_d    = min2_q;
    vreg_d    = vreg_q;
    treg_d    = treg_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_d     = err_q;
    msg_ready = 1'b0;
    fu_valid  = 1'b0;
    op_sel    = OP_ADD;
    op_a      = '0;
    op_b      = '0;

    unique case (state_q)
      ST_IDLE: begin
        msg_ready = 1'b1;
        if (bus.msg_valid_i) begin
          vreg_d  = bus.msg_data_i;
          cnt_d   = cnt_inc;
          // Hitting MAX_DEG closes the node; it is an error only when the
          // sender did not also mark this message as last.
          last_d  = bus.msg_last_i | deg_hit;
          err_d   = ~bus.msg_last_i & deg_hit;
          state_d = ST_OP_MAX;
        end
      end

      ST_OP_MAX: begin
        // max(min1, v) is the candidate for the new second minimum.
        fu_valid = 1'b1;
        op_sel   = OP_LDN_IDXMINUP2;
        op_a     = min1_q;
        op_b     = vreg_q;
        treg_d   = alu_res;
        state_d  = ST_OP_MIN2;
      end

      ST_OP_MIN2: begin
        fu_valid = 1'b1;
        op_sel   = OP_LDN_MIN;
        op_a     = min2_q;
        op_b     = treg_q;
        min2_d   = alu_res;
        state_d  = ST_OP_MIN1;
      end

      ST_OP_MIN1: begin
        // min1 is updated last because OP_MAX needed its old value.
        fu_valid = 1'b1;
        op_sel   = OP_LDN_MIN;
        op_a     = min1_q;
        op_b     = vreg_q;
        min1_d   = alu_res;
        state_d  = last_q ? ST_DONE : ST_IDLE;
      end

      ST_DONE: begin
        if (bus.res_ready_i) begin
          min1_d  = MIN_INIT;
          min2_d  = MIN_INIT;
          cnt_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Packed in interface field order: fu, operation, operand_a, operand_b,
  // imm, trans_id. Idle cycles present an all-zero word (operator ADD).
  always_comb begin
    bus.fu_data_o = '0;
    if (fu_valid) begin
      bus.fu_data_o = {FU_ALU, op_sel, XLEN'(op_a), XLEN'(op_b),
                       {XLEN{1'b0}}, {TID_W{1'b0}}};
    end
  end

  assign bus.fu_valid_o  = fu_valid;
  assign bus.msg_ready_o = msg_ready;
  assign bus.res_valid_o = (state_q == ST_DONE);
  assign bus.res_min1_o  = min1_q;
  assign bus.res_min2_o  = min2_q;
  assign bus.res_count_o = cnt_q;
  assign bus.res_err_o   = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ldn_cn_minsel_issue.sv
module tb_ldn_cn_minsel_issue;

  localparam int          MAX_DEG          = 16;
  localparam logic [3:0]  FU_ALU           = 4'd3;
  localparam logic [7:0]  OP_LDN_MIN       = 8'd114;
  localparam logic [7:0]  OP_LDN_IDXMINUP2 = 8'd115;
  localparam logic [31:0] INIT             = 32'h7F7F7F7F;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ldn_cn_minsel_issue_if mif ();
  logic [2:0] dbg_state;

  ldn_cn_minsel_issue #(.MAX_DEG(MAX_DEG)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (mif),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int          n_vec = 0;
  int          n_err = 0;
  int          acc_cyc = 0;
  bit          hold = 1'b0;
  logic [31:0] alu_hi = '0;
  logic [69:0] exp_q[$];     // {err, count[4:0], min2, min1}
  logic [31:0] node_q[$];    // messages of the node currently being folded
  int          res_seen = 0;
  int          fu_cnt = 0;
  int          stall = 0;
  int          max_stall = 0;
  int          cur_lat = 0;
  logic [31:0] got_min1, got_min2;
  int          got_cnt, got_fu, got_lat;
  logic        got_err;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- ALU model
  function automatic logic [31:0] alu_fn(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    r = a + b;
    for (int l = 0; l < 4; l++) begin
      logic signed [7:0] x, y;
      x = a[8*l +: 8];
      y = b[8*l +: 8];
      if (op == OP_LDN_MIN)            r[8*l +: 8] = (x < y) ? x : y;
      else if (op == OP_LDN_IDXMINUP2) r[8*l +: 8] = (x > y) ? x : y;
    end
    return r;
  endfunction

  assign mif.alu_result_i = {alu_hi, alu_fn(mif.fu_data_o.operation,
                                            mif.fu_data_o.operand_a[31:0],
                                            mif.fu_data_o.operand_b[31:0])};

  // ---------------------------------------------------------------- reference model
  // Two smallest values per lane over the node, starting from +127.
  task automatic model_accept(input logic [31:0] d, input logic l);
    logic [31:0] r1, r2;
    node_q.push_back(d);
    if (l || node_q.size() == MAX_DEG) begin
      r1 = '0;
      r2 = '0;
      for (int lane = 0; lane < 4; lane++) begin
        int m1 = 127;
        int m2 = 127;
        foreach (node_q[k]) begin
          logic [31:0] w;
          int v;
          w = node_q[k];
          v = $signed(w[8*lane +: 8]);
          if (v < m1) begin
            m2 = m1;
            m1 = v;
          end else if (v < m2) begin
            m2 = v;
          end
        end
        r1[8*lane +: 8] = 8'(m1);
        r2[8*lane +: 8] = 8'(m2);
      end
      exp_q.push_back({!l, 5'(node_q.size()), r2, r1});
      node_q.delete();
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic send_msg(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    mif.msg_valid_i = 1'b1;
    mif.msg_data_i  = d;
    mif.msg_last_i  = l;
    for (int i = 0; i < 80 && !ok; i++) begin
      if (mif.msg_ready_o) begin
        @(posedge clk);
        ok      = 1'b1;
        acc_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check("msg_accept", 72'(ok), 72'(1));
    if (ok) model_accept(d, l);
    #1;
    mif.msg_valid_i = 1'b0;
  endtask

  task automatic wait_res(input logic [31:0] m1, input logic [31:0] m2, input int c,
                          input logic e, input int fu);
    int start;
    start = res_seen;
    for (int i = 0; i < 200 && res_seen == start; i++) @(negedge clk);
    check("res_arrived", 72'(res_seen != start), 72'(1));
    check("lit_min1", 72'(got_min1), 72'(m1));
    check("lit_min2", 72'(got_min2), 72'(m2));
    check("lit_count", 72'(got_cnt), 72'(c));
    check("lit_err", 72'(got_err), 72'(e));
    check("lit_fu_cycles", 72'(got_fu), 72'(fu));
  endtask

  task automatic check_reset();
    check("rst_res_valid", 72'(mif.res_valid_o), 72'(0));
    check("rst_fu_valid", 72'(mif.fu_valid_o), 72'(0));
    check("rst_msg_ready", 72'(mif.msg_ready_o), 72'(1));
    check("rst_fu_data", 72'(mif.fu_data_o === '0), 72'(1));
    check("rst_count", 72'(mif.res_count_o), 72'(0));
    check("rst_err", 72'(mif.res_err_o), 72'(0));
    check("rst_min1", 72'(mif.res_min1_o), 72'(INIT));
    check("rst_min2", 72'(mif.res_min2_o), 72'(INIT));
    check("rst_state", 72'(dbg_state), 72'(0));
  endtask

  // result consumer: random backpressure unless a test holds it off
  initial begin
    mif.res_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      alu_hi          = $urandom;
      mif.res_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------- scoreboard / monitor
  initial begin
    bit          prev_valid;
    logic [69:0] prev_vals, cur, exp;
    prev_valid = 1'b0;
    prev_vals  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        fu_cnt     = 0;
        stall      = 0;
      end else begin
        if (mif.fu_valid_o) begin
          fu_cnt++;
          check("fu_unit", 72'(mif.fu_data_o.fu), 72'(FU_ALU));
          check("fu_imm_tid", 72'({mif.fu_data_o.imm, mif.fu_data_o.trans_id}), 72'(0));
          check("fu_opnd_hi", 72'({mif.fu_data_o.operand_a[63:32],
                                   mif.fu_data_o.operand_b[63:32]}), 72'(0));
        end else begin
          check("fu_idle_zero", 72'(mif.fu_data_o === '0), 72'(1));
        end
        check("msg_ready", 72'(mif.msg_ready_o),
              72'(!(mif.fu_valid_o || mif.res_valid_o)));
        if (mif.res_valid_o) begin
          cur = {mif.res_err_o, mif.res_count_o, mif.res_min2_o, mif.res_min1_o};
          if (!prev_valid) begin
            cur_lat = cyc - acc_cyc;
            check("res_latency", 72'(cur_lat), 72'(4));
          end else begin
            check("res_hold", 72'(cur), 72'(prev_vals));
          end
          if (mif.res_ready_i) begin
            if (exp_q.size() == 0) begin
              check("res_unexpected", 72'(1), 72'(0));
            end else begin
              exp = exp_q.pop_front();
              check("res_min1", 72'(mif.res_min1_o), 72'(exp[31:0]));
              check("res_min2", 72'(mif.res_min2_o), 72'(exp[63:32]));
              check("res_count", 72'(mif.res_count_o), 72'(exp[68:64]));
              check("res_err", 72'(mif.res_err_o), 72'(exp[69]));
              check("fu_per_node", 72'(fu_cnt), 72'(3 * int'(exp[68:64])));
            end
            got_min1   = mif.res_min1_o;
            got_min2   = mif.res_min2_o;
            got_cnt    = int'(mif.res_count_o);
            got_err    = mif.res_err_o;
            got_fu     = fu_cnt;
            got_lat    = cur_lat;
            res_seen++;
            fu_cnt     = 0;
            stall      = 0;
            prev_valid = 1'b0;
          end else begin
            prev_valid = 1'b1;
            prev_vals  = cur;
            stall++;
            if (stall > max_stall) max_stall = stall;
          end
        end else begin
          prev_valid = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    mif.msg_valid_i = 1'b0;
    mif.msg_data_i  = '0;
    mif.msg_last_i  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // degree 3
    send_msg(32'h0A0A0A0A, 1'b0);
    send_msg(32'h03030303, 1'b0);
    send_msg(32'h07070707, 1'b1);
    wait_res(32'h03030303, 32'h07070707, 3, 1'b0, 9);

    // signed lanes
    send_msg(32'hFF050000, 1'b0);
    send_msg(32'h01FE0000, 1'b1);
    wait_res(32'hFFFE0000, 32'h01050000, 2, 1'b0, 6);

    // single message
    send_msg(32'h11223344, 1'b1);
    wait_res(32'h11223344, INIT, 1, 1'b0, 3);
    check("lat_single", 72'(got_lat), 72'(4));

    // result backpressure with a message waiting
    max_stall = 0;
    hold      = 1'b1;
    send_msg(32'h7FF08001, 1'b1);
    fork
      begin
        repeat (16) @(posedge clk);
        hold = 1'b0;
      end
    join_none
    send_msg(32'h05050505, 1'b1);
    check("bp_min1", 72'(got_min1), 72'(32'h7FF08001));
    check("bp_min2", 72'(got_min2), 72'(INIT));
    check("bp_stall", 72'(max_stall >= 10), 72'(1));
    wait_res(32'h05050505, INIT, 1, 1'b0, 3);

    // MAX_DEG boundary, then a fresh node
    for (int k = 0; k < 16; k++) send_msg({4{8'(16 - k)}}, 1'b0);
    wait_res(32'h01010101, 32'h02020202, 16, 1'b1, 48);
    send_msg(32'h33333333, 1'b1);
    wait_res(32'h33333333, INIT, 1, 1'b0, 3);

    // reset during OP_MIN2 of the second message
    send_msg(32'h50505050, 1'b0);
    send_msg(32'h40404040, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_state_was_min2", 72'(dbg_state), 72'(0));
    check_reset();
    node_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_msg(32'h20202020, 1'b1);
    wait_res(32'h20202020, INIT, 1, 1'b0, 3);

    // randomized nodes, small lane range so duplicates are common
    for (int n = 0; n < 30; n++) begin
      int deg;
      deg = $urandom_range(1, 20);
      for (int k = 0; k < deg; k++) begin
        logic [31:0] d;
        for (int l = 0; l < 4; l++) begin
          if ($urandom_range(0, 3) == 0) d[8*l +: 8] = 8'($urandom);
          else d[8*l +: 8] = 8'($urandom_range(0, 6) - 3);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_msg(d, k == deg - 1);
      end
    end

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 72'(exp_q.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldn_cn_minsel_issue.md
# ldn_cn_minsel_issue

Check-node min-selection issue unit for the i8x4 non-binary LDPC path. It accepts a stream of packed 4-lane signed 8-bit messages and drives the ALU functional-unit interface with a fixed sequence of LDN ops per message. It reads the ALU result back in the same cycle and accumulates per-lane min1/min2. The block sits on the issuing side of the ALU: it produces `fu_data_t` and consumes `result_o`/`alu_branch_res_o`. On the last message it presents {min1, min2, count} on a valid/ready result port.

## Interface
- `Q`, 8: lane width in bits; fixed by the ALU LDN ops.
- `SIMD`, 4: lanes per message; `Q*SIMD` = 32.
- `MAX_DEG`, 16: maximum messages per check node (2..31).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `msg_valid_i`  in  1  message valid.
- `msg_ready_o`  out  1  message accepted when valid&ready.
- `msg_data_i`  in  32  4 signed lanes, lane i = bits [8i+7:8i].
- `msg_last_i`  in  1  final message of current check node.
- `fu_data_o`  out  fu_data_t  ALU request. fu=ALU, trans_id=0, imm=0, operands zero-extended to XLEN.
- `fu_valid_o`  out  1  `fu_data_o` carries a live LDN op.
- `alu_result_i`  in  XLEN  ALU `result_o`, combinational from `fu_data_o`; bits [31:0] used.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result consumed when valid&ready.
- `res_min1_o`  out  32  per-lane minimum.
- `res_min2_o`  out  32  per-lane second minimum (duplicates count).
- `res_count_o`  out  5  messages folded.
- `res_err_o`  out  1  MAX_DEG reached without `msg_last_i`.

## Operation
- Registers: `min1`, `min2`, `vreg`, `treg` (32b each); `cnt` (5b); `last_q`; `err_q`. State is one of IDLE, OP_MAX, OP_MIN2, OP_MIN1, DONE.
- IDLE: `msg_ready_o`=1. On handshake: `vreg`<=data; `cnt`<=cnt+1; `last_q`<=msg_last_i | (cnt+1==MAX_DEG); `err_q`<=~msg_last_i & (cnt+1==MAX_DEG). Go to OP_MAX.
- OP_MAX: operator LDN_IDXMINUP2, a=min1, b=vreg. `treg`<=alu_result_i[31:0], which is the per-lane signed max. Go to OP_MIN2.
- OP_MIN2: operator LDN_MIN, a=min2, b=treg. `min2`<=result. Go to OP_MIN1.
- OP_MIN1: operator LDN_MIN, a=min1, b=vreg. `min1`<=result. Go to DONE if `last_q`, else IDLE.
- DONE: `res_valid_o`=1 and outputs stable. On `res_ready_i`: min1,min2<=32'h7F7F7F7F; cnt,last_q,err_q<=0. Go to IDLE.
- `fu_valid_o`=1 only in OP_* states. Otherwise `fu_data_o` is all zero (operator ADD).
- All compares are signed per lane, performed by the ALU. No arithmetic is done locally other than `cnt`.
- Identity: min1/min2 start at +127 per lane. A single-message node yields min2 = 0x7F per lane.
- `msg_ready_o`=0 in every state except IDLE. Messages are never dropped.
- `alu_result_i` bits above 31 are ignored. `alu_branch_res_o` is unused.

## Timing
- Reset (async, `rst_ni`=0) forces:
  - state IDLE;
  - min1, min2 = 32'h7F7F7F7F;
  - vreg, treg, cnt, last_q, err_q = 0;
  - outputs: `res_valid_o`=0, `fu_valid_o`=0, `msg_ready_o`=1, `fu_data_o`=0, `res_count_o`=0, `res_err_o`=0.
- A reset mid-sequence discards the partial node with no output.
- Message accept is at cycle 0. ALU ops occupy cycles 1, 2, 3. The next accept is possible at cycle 4.
- Throughput is 1 message per 4 cycles.
- `res_valid_o` rises the cycle after OP_MIN1 of the last message, i.e. cycle 4 relative to the last accept.
- `res_*` hold while `res_valid_o`&~`res_ready_i`. `msg_ready_o` stays 0 during that backpressure.
- After a result handshake, the next message can be accepted the following cycle.
- MAX_DEG boundary: the MAX_DEG-th message is treated as last. `res_err_o`=1 unless `msg_last_i` was also set on it. The following message starts a new node.

## Test plan
- Degree 3, messages 0x0A0A0A0A, 0x03030303, 0x07070707 (last) -> min1=0x03030303, min2=0x07070707, count=3, err=0. `fu_valid_o` high exactly 9 cycles.
- Signed lanes, messages 0xFF050000 and 0x01FE0000 (last) -> min1=0xFFFE0000, min2=0x01050000, count=2.
- Single message 0x11223344 with last -> min1=0x11223344, min2=0x7F7F7F7F, count=1. `res_valid_o` 4 cycles after accept.
- Hold `res_ready_i`=0 for 10 cycles with `msg_valid_i`=1 -> `res_*` stable, `msg_ready_o`=0, no `fu_valid_o`. After release, the next node starts from min1=min2=0x7F7F7F7F.
- 16 messages 0x10101010 down to 0x01010101, no last -> result after the 16th with count=16, err=1, min1=0x01010101, min2=0x02020202. The 17th message opens a new node.
- Assert `rst_ni` low during OP_MIN2 of the second message -> immediate reset values. A following degree-1 node 0x20202020 returns min1=0x20202020, count=1.
